// File: rtl/tristate_bus_reader.sv
// -----------------------------------------------------------------------------
// tristate_bus_reader
//
// Receiving end of a shared tri-state data bus. Up to N_SRC sources raise a
// request. A round-robin arbiter picks one winner and turns on that source's
// tri-state drive enable for exactly one cycle. The bus is sampled on the edge
// that closes that cycle. The captured word is then offered on a valid/ready
// output, tagged with the id of the source that drove it. Only one transfer is
// in flight at a time, so at most one drive enable is ever high.
//
// Output handshake: data_out and src_id are qualified by out_valid. A word is
// consumed on a rising edge where out_valid && out_ready. While out_valid is
// high and out_ready is low, data_out, src_id and out_valid stay frozen.
// out_valid never drops without a completed handshake, except on reset.
//
// Parameters
//   WIDTH  bus and data width
//   N_SRC  number of bus sources (2..8)
//   SRC_W  source id width, ceil(log2(N_SRC)), minimum 1
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   bus        resolved value of the shared tri-state bus
//   req        per-source request, held until that source's en is seen
//   en         per-source drive enable; one-hot or zero; registered
//   data_out   captured bus word
//   src_id     index of the source that drove data_out
//   out_valid  data_out / src_id valid
//   out_ready  consumer accepts the word
//   state_dbg  current FSM state (0 IDLE, 1 DRIVE, 2 HOLD), for observation
// -----------------------------------------------------------------------------
module tristate_bus_reader #(
    parameter int WIDTH = 16,
    parameter int N_SRC = 4,
    parameter int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bus,
    input  logic [N_SRC-1:0] req,
    output logic [N_SRC-1:0] en,
    output logic [WIDTH-1:0] data_out,
    output logic [SRC_W-1:0] src_id,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;       // round-robin search start
    logic [SRC_W-1:0] grant_q, grant_d;   // source owning the current transfer
    logic [N_SRC-1:0] en_q, en_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SRC_W-1:0] src_id_q, src_id_d;
    logic             valid_q, valid_d;

    logic             win_found;
    logic [SRC_W-1:0] win_idx;
    logic             accept;

    // Adds an offset to a source index and wraps at N_SRC, not at 2**SRC_W,
    // so non-power-of-two source counts never produce an id >= N_SRC.
    // Callers only pass base < N_SRC and off <= N_SRC.
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base,
                                                  input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_SRC) begin
            sum = sum - N_SRC;
        end
        return SRC_W'(sum);
    endfunction

    // -------------------------------------------------------------------------
    // Round-robin arbiter: scan from ptr_q upward, wrapping, first set req wins.
    // -------------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!win_found && req[wrap_add(ptr_q, i)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(ptr_q, i);
            end
        end
    end

    assign accept = valid_q && out_ready;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            en_q     <= '0;
            data_q   <= '0;
            src_id_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            en_q     <= en_d;
            data_q   <= data_d;
            src_id_q <= src_id_d;
            valid_q  <= valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output / datapath next values
    // en_d defaults to zero, so an enable can only be high in the single cycle
    // following an IDLE grant; every other state drops it.
    // -------------------------------------------------------------------------
    always_comb begin
        en_d     = '0;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        data_d   = data_q;
        src_id_d = src_id_q;
        valid_d  = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    en_d    = {{(N_SRC-1){1'b0}}, 1'b1} << win_idx;
                    grant_d = win_idx;
                end
            end
            ST_DRIVE: begin
                // The bus is sampled even if the winner dropped req meanwhile.
                data_d   = bus;
                src_id_d = grant_q;
                valid_d  = 1'b1;
                ptr_d    = wrap_add(grant_q, 1);
            end
            ST_HOLD: begin
                if (accept) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    assign en        = en_q;
    assign data_out  = data_q;
    assign src_id    = src_id_q;
    assign out_valid = valid_q;
    assign state_dbg = state_q;

    // Bus-contention invariant: never more than one drive enable.
    a_en_onehot0: assert property (@(posedge clk) $onehot0(en_q));

    // An enable is only ever high while in DRIVE.
    a_en_only_in_drive: assert property (@(posedge clk)
        (en_q != '0) |-> (state_q == ST_DRIVE));

    // Held word stays frozen under back-pressure.
    a_hold_stable: assert property (@(posedge clk) disable iff (reset)
        (valid_q && !out_ready) |=> (valid_q && $stable(data_q) && $stable(src_id_q)));

endmodule
